tm_tape_viewer: RTL and testbench

- Read-side companion to the Turing machine input loader: once computation finishes, it reads tape cells back from the tape RAM and presents a scrollable window of symbols on the LED bus.
- The user steps the window right/left with two debounced push-buttons.
- Sits between the tape RAM read port and the board LED/button pins in the FPGA top.

---
 rtl/tm_tape_viewer.sv | 141 ++++++++++++++
 tb/tb_tm_tape_viewer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tm_tape_viewer.sv
// Tape read-back viewer: loads a WINDOW-cell slice of the tape RAM and scrolls it
// left/right on debounced button edges, showing the head position within the slice.
module tm_tape_viewer #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned WINDOW = 5,
  parameter int unsigned SYM_W  = 2,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned DW    = WINDOW * SYM_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              compute_done,
  input  logic [AW-1:0]     head_pos,
  input  logic              next_btn,
  input  logic              prev_btn,
  output logic              rd_en,
  output logic [AW-1:0]     rd_addr,
  input  logic [SYM_W-1:0]  rd_data,
  output logic [DW-1:0]     window_data,
  output logic [AW-1:0]     window_base,
  output logic [WINDOW-1:0] head_mark,
  output logic              busy,
  output logic              at_left,
  output logic              at_right
);

  localparam logic [AW-1:0] MAX_BASE = AW'(DEPTH - WINDOW);
  localparam logic [AW-1:0] LAST_OFS = AW'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_LAST, SHOW} state_t;

  state_t          state;
  logic [1:0]      next_sync;
  logic [1:0]      prev_sync;
  logic            next_q;
  logic            prev_q;
  logic            next_edge;
  logic            prev_edge;
  logic            rd_q;
  logic            shown;
  logic [AW-1:0]   target;
  logic [DW-1:0]   shadow;
  logic [DW-1:0]   cap_word;

  assign next_edge = next_sync[1] & ~next_q;
  assign prev_edge = prev_sync[1] & ~prev_q;

  // Returning data shifts in from the top so slot 0 ends up holding the first read.
  assign cap_word = DW'({rd_data, shadow} >> SYM_W);

  assign at_left  = (window_base == '0);
  assign at_right = (window_base == MAX_BASE);

  // Head marker only refers to a window that has actually been displayed.
  always_comb begin
    head_mark = '0;
    for (int unsigned i = 0; i < WINDOW; i++) begin
      head_mark[i] = shown && (head_pos == window_base + AW'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      next_sync   <= '0;
      prev_sync   <= '0;
      next_q      <= 1'b0;
      prev_q      <= 1'b0;
      rd_q        <= 1'b0;
      shown       <= 1'b0;
      target      <= '0;
      shadow      <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      window_data <= '0;
      window_base <= '0;
      busy        <= 1'b0;
    end else begin
      next_sync <= {next_sync[0], next_btn};
      prev_sync <= {prev_sync[0], prev_btn};
      next_q    <= next_sync[1];
      prev_q    <= prev_sync[1];
      rd_q      <= rd_en;

      if (!compute_done) begin
        state       <= IDLE;
        target      <= '0;
        rd_en       <= 1'b0;
        rd_addr     <= '0;
        window_data <= '0;
        window_base <= '0;
        busy        <= 1'b0;
        shown       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            target  <= '0;
            rd_addr <= '0;
            rd_en   <= 1'b1;
            busy    <= 1'b1;
            state   <= LOAD;
          end
          LOAD: begin
            if (rd_q) shadow <= cap_word;
            if (rd_addr == target + LAST_OFS) begin
              rd_en <= 1'b0;
              state <= WAIT_LAST;
            end else begin
              rd_addr <= rd_addr + AW'(1);
            end
          end
          WAIT_LAST: begin
            window_data <= cap_word;
            window_base <= target;
            busy        <= 1'b0;
            shown       <= 1'b1;
            state       <= SHOW;
          end
          SHOW: begin
            // Simultaneous edges cancel; a step into a boundary is ignored.
            if (next_edge && !prev_edge && !at_right) begin
              target  <= window_base + AW'(1);
              rd_addr <= window_base + AW'(1);
              rd_en   <= 1'b1;
              busy    <= 1'b1;
              state   <= LOAD;
            end else if (prev_edge && !next_edge && !at_left) begin
              target  <= window_base - AW'(1);
              rd_addr <= window_base - AW'(1);
              rd_en   <= 1'b1;
              busy    <= 1'b1;
              state   <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tm_tape_viewer.sv
// Bench for tm_tape_viewer: tape RAM model plus a window model computed directly
// from tape contents, base position and head position.
module tb_tm_tape_viewer;

  localparam int DEPTH    = 32;
  localparam int WINDOW   = 5;
  localparam int SYM_W    = 2;
  localparam int AW       = 5;
  localparam int DW       = WINDOW * SYM_W;
  localparam int MAX_BASE = DEPTH - WINDOW;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              compute_done;
  logic [AW-1:0]     head_pos;
  logic              next_btn;
  logic              prev_btn;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [SYM_W-1:0]  rd_data;
  logic [DW-1:0]     window_data;
  logic [AW-1:0]     window_base;
  logic [WINDOW-1:0] head_mark;
  logic              busy;
  logic              at_left;
  logic              at_right;

  logic [SYM_W-1:0] mem [DEPTH];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               model_base;
  int               busy_cnt;
  int               partial_cnt;
  logic [DW-1:0]    hold_win;
  int               reads[$];

  tm_tape_viewer #(.DEPTH(DEPTH), .WINDOW(WINDOW), .SYM_W(SYM_W)) dut (
    .clock(clock), .reset_n(reset_n), .compute_done(compute_done), .head_pos(head_pos),
    .next_btn(next_btn), .prev_btn(prev_btn), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .window_data(window_data), .window_base(window_base),
    .head_mark(head_mark), .busy(busy), .at_left(at_left), .at_right(at_right)
  );

  always #5 clock = ~clock;

  // Tape RAM: one-cycle read latency.
  always @(posedge clock) if (rd_en) rd_data <= mem[rd_addr];

  function automatic logic [DW-1:0] exp_window(int base);
    logic [DW-1:0] w;
    w = '0;
    for (int i = 0; i < WINDOW; i++) w[i*SYM_W +: SYM_W] = mem[base + i];
    return w;
  endfunction

  function automatic logic [WINDOW-1:0] exp_mark(int base);
    logic [WINDOW-1:0] m;
    for (int i = 0; i < WINDOW; i++) m[i] = (int'(head_pos) == base + i);
    return m;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(negedge clock);
      if (rd_en) reads.push_back(int'(rd_addr));
      if (busy) busy_cnt++;
      if (busy && window_data !== hold_win) partial_cnt++;
    end
  endtask

  task automatic clear_log(logic [DW-1:0] hold);
    reads.delete();
    busy_cnt    = 0;
    partial_cnt = 0;
    hold_win    = hold;
  endtask

  task automatic press(bit nxt, int hold);
    if (nxt) next_btn = 1'b1; else prev_btn = 1'b1;
    step(hold);
    next_btn = 1'b0;
    prev_btn = 1'b0;
    step(WINDOW + 8);
  endtask

  task automatic fresh_load();
    compute_done = 1'b0;
    step(3);
    compute_done = 1'b1;
    clear_log('0);
    step(WINDOW + 6);
    model_base = 0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(3);
    n_checks++; if (window_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", window_data); end
    n_checks++; if (window_base !== '0) begin n_fail++; $display("FAIL reset_base: got %0d want 0", window_base); end
    n_checks++; if (rd_en !== 1'b0 || rd_addr !== '0) begin n_fail++; $display("FAIL reset_rd: got en=%b addr=%0d want 0/0", rd_en, rd_addr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (head_mark !== '0) begin n_fail++; $display("FAIL reset_mark: got %b want 0", head_mark); end
    n_checks++; if (at_left !== 1'b1 || at_right !== 1'b0) begin n_fail++; $display("FAIL reset_bounds: got l=%b r=%b want 1/0", at_left, at_right); end
    reset_n = 1'b1;
    step(2);
  endtask

  task automatic test_initial_load();
    compute_done = 1'b1;
    clear_log('0);
    step(WINDOW + 6);
    model_base = 0;
    n_checks++; if (reads.size() != WINDOW) begin n_fail++; $display("FAIL init_nreads: got %0d want %0d", reads.size(), WINDOW); end
    for (int k = 0; k < reads.size() && k < WINDOW; k++) begin
      n_checks++; if (reads[k] != k) begin n_fail++; $display("FAIL init_addr%0d: got %0d want %0d", k, reads[k], k); end
    end
    n_checks++; if (busy_cnt != WINDOW + 1) begin n_fail++; $display("FAIL init_busy: got %0d want %0d", busy_cnt, WINDOW + 1); end
    n_checks++; if (window_data !== 10'b00_11_10_01_00) begin n_fail++; $display("FAIL init_data: got %b want 0011100100", window_data); end
    n_checks++; if (head_mark !== 5'b00100) begin n_fail++; $display("FAIL init_mark: got %b want 00100", head_mark); end
    n_checks++; if (at_left !== 1'b1 || window_base !== '0) begin n_fail++; $display("FAIL init_left: got l=%b base=%0d want 1/0", at_left, window_base); end
    n_checks++; if (partial_cnt != 0) begin n_fail++; $display("FAIL init_atomic: got %0d partial samples want 0", partial_cnt); end
  endtask

  task automatic test_next_press();
    clear_log(exp_window(0));
    press(1'b1, 2);
    model_base = 1;
    n_checks++; if (reads.size() != WINDOW) begin n_fail++; $display("FAIL next_nreads: got %0d want %0d", reads.size(), WINDOW); end
    n_checks++; if (reads.size() > 0 && reads[0] != 1) begin n_fail++; $display("FAIL next_addr0: got %0d want 1", reads[0]); end
    n_checks++; if (window_base !== AW'(1)) begin n_fail++; $display("FAIL next_base: got %0d want 1", window_base); end
    n_checks++; if (window_data !== 10'b01_00_11_10_01) begin n_fail++; $display("FAIL next_data: got %b want 0100111001", window_data); end
    n_checks++; if (head_mark !== 5'b00010) begin n_fail++; $display("FAIL next_mark: got %b want 00010", head_mark); end
    n_checks++; if (partial_cnt != 0) begin n_fail++; $display("FAIL next_atomic: got %0d partial samples want 0", partial_cnt); end
  endtask

  task automatic test_press_while_busy();
    clear_log(exp_window(model_base));
    next_btn = 1'b1;
    step(2);
    next_btn = 1'b0;
    step(2);
    next_btn = 1'b1;
    step(2);
    next_btn = 1'b0;
    step(WINDOW + 8);
    model_base = model_base + 1;
    n_checks++; if (reads.size() != WINDOW) begin n_fail++; $display("FAIL busy_nreads: got %0d want %0d", reads.size(), WINDOW); end
    n_checks++; if (window_base !== AW'(model_base)) begin n_fail++; $display("FAIL busy_base: got %0d want %0d", window_base, model_base); end
    n_checks++; if (window_data !== exp_window(model_base)) begin n_fail++; $display("FAIL busy_data: got %b want %b", window_data, exp_window(model_base)); end
  endtask

  task automatic test_simultaneous();
    clear_log(exp_window(model_base));
    next_btn = 1'b1;
    prev_btn = 1'b1;
    step(2);
    next_btn = 1'b0;
    prev_btn = 1'b0;
    step(WINDOW + 8);
    n_checks++; if (reads.size() != 0) begin n_fail++; $display("FAIL both_nreads: got %0d want 0", reads.size()); end
    n_checks++; if (window_base !== AW'(model_base)) begin n_fail++; $display("FAIL both_base: got %0d want %0d", window_base, model_base); end
  endtask

  task automatic test_boundaries();
    fresh_load();
    clear_log(exp_window(0));
    for (int p = 0; p < MAX_BASE; p++) begin
      hold_win = exp_window(p);
      press(1'b1, 1);
    end
    model_base = MAX_BASE;
    n_checks++; if (reads.size() != MAX_BASE * WINDOW) begin n_fail++; $display("FAIL walk_nreads: got %0d want %0d", reads.size(), MAX_BASE * WINDOW); end
    n_checks++; if (window_base !== AW'(MAX_BASE) || at_right !== 1'b1) begin n_fail++; $display("FAIL walk_right: got base=%0d r=%b want %0d/1", window_base, at_right, MAX_BASE); end
    n_checks++; if (window_data !== exp_window(MAX_BASE)) begin n_fail++; $display("FAIL walk_data: got %b want %b", window_data, exp_window(MAX_BASE)); end
    clear_log(exp_window(MAX_BASE));
    press(1'b1, 2);
    n_checks++; if (reads.size() != 0) begin n_fail++; $display("FAIL right_stop_reads: got %0d want 0", reads.size()); end
    n_checks++; if (window_base !== AW'(MAX_BASE)) begin n_fail++; $display("FAIL right_stop_base: got %0d want %0d", window_base, MAX_BASE); end
    fresh_load();
    clear_log(exp_window(0));
    press(1'b0, 2);
    n_checks++; if (reads.size() != 0) begin n_fail++; $display("FAIL left_stop_reads: got %0d want 0", reads.size()); end
    n_checks++; if (window_base !== '0 || at_left !== 1'b1) begin n_fail++; $display("FAIL left_stop_base: got base=%0d l=%b want 0/1", window_base, at_left); end
  endtask

  task automatic wait_busy(string tag);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin step(1); n++; end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_start: got busy=%b want 1 within 20 cycles", tag, busy); end
  endtask

  task automatic test_abort();
    next_btn = 1'b1;
    step(1);
    next_btn = 1'b0;
    wait_busy("abort");
    step(2);
    compute_done = 1'b0;
    step(1);
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL abort_rd_en: got %b want 0", rd_en); end
    n_checks++; if (window_data !== '0 || window_base !== '0) begin n_fail++; $display("FAIL abort_clear: got data=%b base=%0d want 0/0", window_data, window_base); end
    n_checks++; if (busy !== 1'b0 || head_mark !== '0) begin n_fail++; $display("FAIL abort_flags: got busy=%b mark=%b want 0/0", busy, head_mark); end
    compute_done = 1'b1;
    clear_log('0);
    step(WINDOW + 6);
    model_base = 0;
    n_checks++; if (reads.size() != WINDOW || reads[0] != 0) begin n_fail++; $display("FAIL reload_reads: got n=%0d want %0d from 0", reads.size(), WINDOW); end
    n_checks++; if (window_data !== exp_window(0) || window_base !== '0) begin n_fail++; $display("FAIL reload_data: got %b base=%0d want %b/0", window_data, window_base, exp_window(0)); end
  endtask

  task automatic test_reset_midload();
    next_btn = 1'b1;
    step(1);
    next_btn = 1'b0;
    wait_busy("rstload");
    step(1);
    reset_n = 1'b0;
    step(1);
    n_checks++; if (rd_en !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstload_flags: got en=%b busy=%b want 0/0", rd_en, busy); end
    n_checks++; if (window_data !== '0 || window_base !== '0 || head_mark !== '0) begin n_fail++; $display("FAIL rstload_clear: got data=%b base=%0d mark=%b want 0", window_data, window_base, head_mark); end
    reset_n = 1'b1;
    clear_log('0);
    step(WINDOW + 6);
    model_base = 0;
    n_checks++; if (window_data !== exp_window(0) || window_base !== '0) begin n_fail++; $display("FAIL rstload_reload: got %b base=%0d want %b/0", window_data, window_base, exp_window(0)); end
  endtask

  task automatic test_random_scroll();
    compute_done = 1'b0;
    step(2);
    for (int i = 0; i < DEPTH; i++) mem[i] = SYM_W'($urandom_range(0, 3));
    head_pos = AW'($urandom_range(0, DEPTH - 1));
    fresh_load();
    n_checks++; if (window_data !== exp_window(0)) begin n_fail++; $display("FAIL rand_load: got %b want %b", window_data, exp_window(0)); end
    for (int it = 0; it < 40; it++) begin
      bit nxt;
      int hold;
      int exp_base;
      int exp_reads;
      nxt = ($urandom_range(0, 2) != 0);
      hold = $urandom_range(1, 3);
      exp_base = model_base;
      exp_reads = 0;
      if (nxt && model_base < MAX_BASE) begin exp_base = model_base + 1; exp_reads = WINDOW; end
      else if (!nxt && model_base > 0) begin exp_base = model_base - 1; exp_reads = WINDOW; end
      clear_log(exp_window(model_base));
      press(nxt, hold);
      model_base = exp_base;
      n_checks++; if (reads.size() != exp_reads) begin n_fail++; $display("FAIL rand%0d_nreads: got %0d want %0d", it, reads.size(), exp_reads); end
      n_checks++; if (window_base !== AW'(exp_base)) begin n_fail++; $display("FAIL rand%0d_base: got %0d want %0d", it, window_base, exp_base); end
      n_checks++; if (window_data !== exp_window(exp_base)) begin n_fail++; $display("FAIL rand%0d_data: got %b want %b", it, window_data, exp_window(exp_base)); end
      n_checks++; if (head_mark !== exp_mark(exp_base)) begin n_fail++; $display("FAIL rand%0d_mark: got %b want %b", it, head_mark, exp_mark(exp_base)); end
      n_checks++; if (at_left !== (exp_base == 0) || at_right !== (exp_base == MAX_BASE)) begin n_fail++; $display("FAIL rand%0d_bounds: got l=%b r=%b base %0d", it, at_left, at_right, exp_base); end
      n_checks++; if (partial_cnt != 0) begin n_fail++; $display("FAIL rand%0d_atomic: got %0d partial samples want 0", it, partial_cnt); end
    end
  endtask

  initial begin
    reset_n      = 1'b0;
    compute_done = 1'b0;
    next_btn     = 1'b0;
    prev_btn     = 1'b0;
    head_pos     = AW'(2);
    model_base   = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = SYM_W'(i % 4);
    clear_log('0);
    test_reset();
    test_initial_load();
    test_next_press();
    test_press_while_busy();
    test_simultaneous();
    test_boundaries();
    test_abort();
    test_reset_midload();
    test_random_scroll();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
